button_debouncer: RTL and testbench

Debounces the player/dealer push-buttons (deal, hit, stand, …) for the blackjack controller. It consumes the free-running microsecond count from the microsecond timer and delivers clean levels plus single-cycle press/release pulses to the game FSM. Each button runs an independent synchronizer and state machine. A change is accepted only after the input has held its new value for DEBOUNCE_US microseconds.

---
 rtl/button_debouncer.sv | 122 ++++++++++++
 tb/tb_button_debouncer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/button_debouncer.sv
// Multi-button debouncer: two-flop synchronizer and a four-state machine per button.
// A level change is accepted once it has held for DEBOUNCE_US ticks of the shared microsecond timer.
module button_debouncer #(
    parameter int NUM_BTN     = 3,
    parameter int DEBOUNCE_US = 5000,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        timeMicro,
    input  logic [NUM_BTN-1:0] btnRaw,
    output logic [NUM_BTN-1:0] btnLevel,
    output logic [NUM_BTN-1:0] btnPress,
    output logic [NUM_BTN-1:0] btnRelease
);

    localparam logic [31:0]        DEB_LIMIT = 32'(DEBOUNCE_US);
    localparam logic [NUM_BTN-1:0] INV_MASK  = (ACTIVE_LOW != 0) ? '1 : '0;

    typedef enum logic [1:0] {
        ST_LOW,
        ST_WAIT_HIGH,
        ST_HIGH,
        ST_WAIT_LOW
    } state_t;

    logic [NUM_BTN-1:0] sync_p0;
    logic [NUM_BTN-1:0] sync_p1;

    // Synchronizer stages: polarity is normalised before the first flop so 1 always means pressed
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= btnRaw ^ INV_MASK;
            sync_p1 <= sync_p0;
        end
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        state_t      state;
        state_t      state_next;
        logic [31:0] stamp;
        logic [31:0] stamp_next;
        logic [31:0] elapsed;
        logic        settled;
        logic        level_q;
        logic        press_q;
        logic        release_q;
        logic        level_next;
        logic        press_next;
        logic        release_next;

        // Modulo-2^32 difference stays correct when the timer wraps inside a window
        assign elapsed = timeMicro - stamp;
        assign settled = (elapsed >= DEB_LIMIT);

        always_comb begin
            state_next   = state;
            stamp_next   = stamp;
            level_next   = level_q;
            press_next   = 1'b0;
            release_next = 1'b0;
            case (state)
                ST_LOW: begin
                    if (sync_p1[i]) begin
                        stamp_next = timeMicro;
                        state_next = ST_WAIT_HIGH;
                    end
                end
                ST_WAIT_HIGH: begin
                    if (!sync_p1[i]) begin
                        state_next = ST_LOW;
                    end else if (settled) begin
                        state_next = ST_HIGH;
                        level_next = 1'b1;
                        press_next = 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (!sync_p1[i]) begin
                        stamp_next = timeMicro;
                        state_next = ST_WAIT_LOW;
                    end
                end
                ST_WAIT_LOW: begin
                    if (sync_p1[i]) begin
                        state_next = ST_HIGH;
                    end else if (settled) begin
                        state_next   = ST_LOW;
                        level_next   = 1'b0;
                        release_next = 1'b1;
                    end
                end
                default: state_next = ST_LOW;
            endcase
        end

        // State register stage: outputs are registered alongside the state
        always_ff @(posedge clk) begin
            if (!rst) begin
                state     <= ST_LOW;
                stamp     <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                state     <= state_next;
                stamp     <= stamp_next;
                level_q   <= level_next;
                press_q   <= press_next;
                release_q <= release_next;
            end
        end

        assign btnLevel[i]   = level_q;
        assign btnPress[i]   = press_q;
        assign btnRelease[i] = release_q;
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer: expected pulses are queued at stimulus time and
// matched against DUT pulses, including the timer value at which each pulse appears.
module tb_button_debouncer;

    localparam int NB        = 3;
    localparam int DEB       = 20;
    localparam int TICK_CLKS = 50;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   time_micro;
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_press;
    logic [NB-1:0] btn_release;

    int            tick_div;
    logic          tm_load;
    logic [31:0]   tm_load_val;
    int            cyc = 0;

    typedef struct {
        bit          rel;
        int          idx;
        logic [31:0] ref_tm;
    } exp_t;

    exp_t          exp_q[$];
    int            vectors     = 0;
    int            miscompares = 0;
    int            last_cyc[2][NB];
    logic [31:0]   last_tm[2][NB];

    always #10 clk = ~clk;

    button_debouncer #(
        .NUM_BTN    (NB),
        .DEBOUNCE_US(DEB),
        .ACTIVE_LOW (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .timeMicro (time_micro),
        .btnRaw    (btn_raw),
        .btnLevel  (btn_level),
        .btnPress  (btn_press),
        .btnRelease(btn_release)
    );

    // Microsecond timer model: one tick every TICK_CLKS clocks, loadable for the wrap test
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tm_load) begin
            time_micro <= tm_load_val;
            tick_div   <= 0;
        end else if (tick_div == TICK_CLKS - 1) begin
            time_micro <= time_micro + 32'd1;
            tick_div   <= 0;
        end else begin
            tick_div <= tick_div + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic take(input bit rel, input int idx);
        exp_t e;
        vectors++;
        assert (exp_q.size() != 0) else begin
            miscompares++;
            $error("FAIL unexpected_pulse observed=%s[%0d] at tm=%0h expected=none",
                   rel ? "release" : "press", idx, time_micro);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("pulse_kind_bit", {rel, 31'(idx)}, {e.rel, 31'(e.idx)});
            check("pulse_delay_us", time_micro - e.ref_tm, 32'(DEB));
        end
        last_cyc[rel][idx] = cyc;
        last_tm[rel][idx]  = time_micro;
    endtask

    // Pulse monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (rst === 1'b1) check("press_release_exclusive", 32'(btn_press & btn_release), 32'd0);
        for (int i = 0; i < NB; i++) begin
            if (btn_press[i] === 1'b1)   take(1'b0, i);
            if (btn_release[i] === 1'b1) take(1'b1, i);
        end
    end

    // Returns on the falling edge right after a timer tick
    task automatic wait_tick(input int n);
        repeat (n) begin
            do @(negedge clk); while (tick_div != 0);
        end
    endtask

    task automatic drive(input int idx, input bit pressed, input bit expect_pulse);
        exp_t e;
        btn_raw[idx] = ~pressed;
        if (expect_pulse) begin
            e.rel    = ~pressed;
            e.idx    = idx;
            e.ref_tm = time_micro;
            exp_q.push_back(e);
        end
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < (DEB + 10) * TICK_CLKS) begin
            @(negedge clk);
            n++;
        end
        check(tag, exp_q.size(), 32'd0);
    endtask

    initial begin
        rst         = 1'b0;
        btn_raw     = '1;
        tm_load     = 1'b1;
        tm_load_val = 32'd0;
        repeat (2) @(negedge clk);
        tm_load = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_level", 32'(btn_level), 32'd0);
        check("reset_press", 32'(btn_press), 32'd0);
        check("reset_release", 32'(btn_release), 32'd0);

        rst = 1'b1;
        wait_tick(100);
        check("idle_level", 32'(btn_level), 32'd0);

        // Clean press and release on bit 0
        wait_tick(1);
        drive(0, 1'b1, 1'b1);
        drain("clean_press_seen");
        check("clean_press_level", 32'(btn_level), 32'b001);
        wait_tick(2);
        drive(0, 1'b0, 1'b1);
        drain("clean_release_seen");
        check("clean_release_level", 32'(btn_level), 32'b000);

        // Bounce on bit 1: toggles every 5 us, ends pressed
        wait_tick(1);
        for (int k = 0; k <= 12; k++) begin
            drive(1, (k % 2) == 0, k == 12);
            if (k < 12) wait_tick(5);
        end
        drain("bounce_press_seen");
        check("bounce_level", 32'(btn_level), 32'b010);
        wait_tick(1);
        drive(1, 1'b0, 1'b1);
        drain("bounce_release_seen");

        // Timer wrap during the window on bit 2
        tm_load_val = 32'hFFFF_FFF0;
        tm_load     = 1'b1;
        @(negedge clk);
        tm_load = 1'b0;
        drive(2, 1'b1, 1'b1);
        drain("wrap_press_seen");
        check("wrap_press_tm", last_tm[0][2], 32'h0000_0004);
        check("wrap_level", 32'(btn_level), 32'b100);
        wait_tick(1);
        drive(2, 1'b0, 1'b1);
        drain("wrap_release_seen");

        // Simultaneous press and release of bits 0 and 2
        wait_tick(1);
        drive(0, 1'b1, 1'b1);
        drive(2, 1'b1, 1'b1);
        drain("simul_press_seen");
        check("simul_press_same_cycle", 32'(last_cyc[0][0]), 32'(last_cyc[0][2]));
        check("simul_level", 32'(btn_level), 32'b101);
        wait_tick(1);
        drive(0, 1'b0, 1'b1);
        drive(2, 1'b0, 1'b1);
        drain("simul_release_seen");
        check("simul_release_same_cycle", 32'(last_cyc[1][0]), 32'(last_cyc[1][2]));
        check("simul_release_level", 32'(btn_level), 32'b000);

        // Reset in the middle of a press window, key held through reset
        wait_tick(1);
        drive(0, 1'b1, 1'b0);
        wait_tick(10);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_level", 32'(btn_level), 32'd0);
        wait_tick(1);
        rst = 1'b1;
        drive(0, 1'b1, 1'b1);
        drain("midrst_press_seen");
        check("midrst_press_level", 32'(btn_level), 32'b001);
        wait_tick(1);
        drive(0, 1'b0, 1'b1);
        drain("midrst_release_seen");

        wait_tick(30);
        check("final_queue_empty", exp_q.size(), 32'd0);
        check("final_level", 32'(btn_level), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
